key_event_queue: RTL and testbench

//  Consumer of the PS/2 decoder's 12-bit held-key bus (ctrl_bus). Synchronises the

---
 rtl/key_evt_pkg.sv | 35 +++
 rtl/key_evt_fifo.sv | 59 +++++
 rtl/key_event_queue.sv | 159 +++++++++++++++
 tb/tb_key_event_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared constants and helpers for the keyboard event queue: key indices,
// event byte layout and the direction-key mask.
package key_evt_pkg;

  localparam int NUM_KEYS = 12;

  localparam int KEY_I  = 0;
  localparam int KEY_SP = 1;
  localparam int KEY_Q  = 2;
  localparam int KEY_P  = 3;
  localparam int KEY_O  = 4;
  localparam int KEY_L  = 5;
  localparam int KEY_K  = 6;
  localparam int KEY_J  = 7;
  localparam int KEY_D  = 8;
  localparam int KEY_S  = 9;
  localparam int KEY_A  = 10;
  localparam int KEY_W  = 11;

  localparam int EVT_PRESS = 7;
  localparam int EVT_REP   = 6;

  localparam logic [NUM_KEYS-1:0] DIR_MASK = 12'hF00;

  // Build an event byte: [7]=press, [6]=repeat, [5:4]=0, [3:0]=key index.
  function automatic logic [7:0] makeEvt(input logic press, input logic rep,
                                         input logic [3:0] idx);
    logic [7:0] evt;
    evt = {4'b0000, idx};
    evt[EVT_PRESS] = press;
    evt[EVT_REP] = rep;
    return evt;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Show-ahead synchronous FIFO for event bytes. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// dropped and flagged for one cycle on 'dropped'.
module key_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             full;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign dropped = push && !doPush;

  // Head is forced to zero while empty so the output is defined from reset.
  assign headData = empty ? '0 : mem[rdPtr];

  // Storage array; no reset needed because reads are gated by 'empty'.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Keyboard event queue: synchronises the held-key bus, converts press and
// release edges into event bytes, adds typematic repeat for W/A/S/D and
// buffers everything in a FIFO popped by the CPU.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 2500000,
  parameter int REPEAT_PERIOD = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ctrl_bus,
  output logic [7:0]  evt_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [11:0] key_state,
  output logic        ovf,
  input  logic        clr_ovf
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [NUM_KEYS-1:0] syncQ1, syncQ2, prevQ;
  logic [NUM_KEYS-1:0] rise, fall;
  logic [NUM_KEYS-1:0] pend, ptype, pendNxt, ptypeNxt, keepPend;

  logic          trkValid;
  logic [1:0]    trkSel;
  logic [CW-1:0] repCnt;
  logic [3:0]    dirRise, dirFall, dirHeld;
  logic [1:0]    newSel;
  logic          repFire;

  logic       serValid;
  logic [3:0] serIdx;
  logic       fifoPush;
  logic [7:0] pushData;
  logic       fifoEmpty;
  logic       fifoDrop;

  assign rise      = syncQ2 & ~prevQ;
  assign fall      = ~syncQ2 & prevQ;
  assign key_state = syncQ2;

  assign dirRise = rise[KEY_D +: 4] & DIR_MASK[KEY_D +: 4];
  assign dirFall = fall[KEY_D +: 4];
  assign dirHeld = syncQ2[KEY_D +: 4];

  // Two-flop synchroniser plus previous-value register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncQ1 <= '0;
      syncQ2 <= '0;
      prevQ  <= '0;
    end else begin
      syncQ1 <= ctrl_bus;
      syncQ2 <= syncQ1;
      prevQ  <= syncQ2;
    end
  end

  // Pick which direction key a rise retargets the tracker to (lowest index wins a tie).
  always_comb begin
    newSel = '0;
    for (int i = 3; i >= 0; i--) begin
      if (dirRise[i]) newSel = 2'(i);
    end
  end

  // A repeat is due when the countdown has expired and the tracked key is still held.
  assign repFire = trkValid && (repCnt == '0) && dirHeld[trkSel];

  // Repeat tracker: a direction-key rise (re)loads it, a fall of the tracked key
  // disables it, otherwise the down-counter runs and reloads on each repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trkValid <= 1'b0;
      trkSel   <= '0;
      repCnt   <= '0;
    end else if (|dirRise) begin
      trkValid <= 1'b1;
      trkSel   <= newSel;
      repCnt   <= CW'(REPEAT_DELAY);
    end else if (trkValid && dirFall[trkSel]) begin
      trkValid <= 1'b0;
    end else if (trkValid) begin
      if (repCnt == '0) repCnt <= CW'(REPEAT_PERIOD - 1);
      else              repCnt <= repCnt - 1'b1;
    end
  end

  // Serializer: lowest pending key, unless a repeat claims this cycle's FIFO slot.
  always_comb begin
    serIdx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) serIdx = 4'(i);
    end
    serValid = (|pend) && !repFire;
    fifoPush = repFire || serValid;
    if (repFire) pushData = makeEvt(1'b1, 1'b1, {2'b10, trkSel});
    else         pushData = makeEvt(ptype[serIdx], 1'b0, serIdx);
  end

  // Pending bookkeeping: the serialized key is retired first, then a new edge
  // either arms an idle key or cancels an opposite pending edge.
  always_comb begin
    pendNxt  = pend;
    ptypeNxt = ptype;
    for (int i = 0; i < NUM_KEYS; i++) begin
      keepPend[i] = pend[i] && !(serValid && (serIdx == 4'(i)));
      pendNxt[i]  = keepPend[i];
      if (rise[i] || fall[i]) begin
        if (keepPend[i]) begin
          pendNxt[i] = 1'b0;
        end else begin
          pendNxt[i]  = 1'b1;
          ptypeNxt[i] = rise[i];
        end
      end
    end
  end

  // Pending flags and their edge types.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      ptype <= '0;
    end else begin
      pend  <= pendNxt;
      ptype <= ptypeNxt;
    end
  end

  // Sticky overflow flag; clear wins over a same-cycle drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (clr_ovf)  ovf <= 1'b0;
    else if (fifoDrop) ovf <= 1'b1;
  end

  key_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushData (pushData),
    .pop      (evt_ready),
    .headData (evt_data),
    .empty    (fifoEmpty),
    .dropped  (fifoDrop)
  );

  assign evt_valid = !fifoEmpty;

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: scoreboard of expected event
// bytes popped by a negedge monitor, plus directed timing/flag checks.
module tb_key_event_queue;

  logic        clk;
  logic        rst;
  logic [11:0] ctrl_bus;
  logic [7:0]  evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [11:0] key_state;
  logic        ovf;
  logic        clr_ovf;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  logic [7:0] expQ [$];

  key_event_queue #(
    .DEPTH         (8),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_bus  (ctrl_bus),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .key_state (key_state),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (expQ.size() == 0) checkEq("extraEvt", {24'h0, evt_data}, 32'h100);
      else                  checkEq("evtData", {24'h0, evt_data}, {24'h0, expQ.pop_front()});
    end
  end

  task automatic drive(input logic [11:0] bus);
    @(posedge clk);
    #1 ctrl_bus = bus;
  endtask

  task automatic waitEvt(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (evt_valid) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  initial begin
    int t0, t1, t2, t3;
    bit ok;

    rst = 1'b1;
    ctrl_bus = '0;
    evt_ready = 1'b1;
    clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEq("rstValid", evt_valid, 0);
    checkEq("rstData", evt_data, 0);
    checkEq("rstOvf", ovf, 0);
    checkEq("rstKeys", key_state, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // 1: J press visible on the 4th edge, then release
    drive(12'h080);
    expQ.push_back(8'h87);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkEq("jLatValid", evt_valid, 1);
    checkEq("jLatData", evt_data, 8'h87);
    checkEq("jKeyState", key_state, 12'h080);
    drive(12'h000);
    expQ.push_back(8'h07);
    waitEvt(10, t0, ok);
    checkEq("jRelSeen", ok, 1);
    repeat (4) @(posedge clk);

    // 2: simultaneous W and I press, serialized lowest index first
    drive(12'h801);
    expQ.push_back(8'h80);
    expQ.push_back(8'h8B);
    waitEvt(10, t0, ok);
    checkEq("wiFirst", ok, 1);
    waitEvt(3, t1, ok);
    checkEq("wiSecond", ok, 1);
    checkEq("wiGap", t1 - t0, 1);
    drive(12'h000);
    expQ.push_back(8'h00);
    expQ.push_back(8'h0B);
    waitEvt(10, t0, ok);
    waitEvt(3, t1, ok);
    checkEq("wiRelSeen", ok, 1);
    repeat (5) @(posedge clk);

    // 3: hold A for typematic repeat
    drive(12'h400);
    expQ.push_back(8'h8A);
    expQ.push_back(8'hCA);
    expQ.push_back(8'hCA);
    expQ.push_back(8'hCA);
    waitEvt(10, t0, ok);
    checkEq("aPress", ok, 1);
    waitEvt(30, t1, ok);
    checkEq("aRep1Seen", ok, 1);
    checkEq("aDelay", t1 - t0, 20);
    waitEvt(10, t2, ok);
    checkEq("aPeriod1", t2 - t1, 5);
    waitEvt(10, t3, ok);
    checkEq("aPeriod2", t3 - t2, 5);
    drive(12'h000);
    expQ.push_back(8'h0A);
    waitEvt(10, t0, ok);
    checkEq("aRelSeen", ok, 1);
    waitEvt(30, t0, ok);
    checkEq("aNoRepeat", ok, 0);

    // 4: overflow with 9 presses while the CPU is not popping
    @(posedge clk);
    #1 evt_ready = 1'b0;
    ctrl_bus = 12'h1FF;
    for (int i = 0; i < 8; i++) expQ.push_back(8'h80 | 8'(i));
    repeat (16) @(posedge clk);
    @(negedge clk);
    checkEq("ovfSet", ovf, 1);
    checkEq("ovfValid", evt_valid, 1);
    checkEq("ovfCount", dut.uFifo.count, 8);
    drive(12'h000);
    repeat (15) @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkEq("ovfDrained", expQ.size(), 0);
    checkEq("ovfSticky", ovf, 1);
    @(posedge clk);
    #1 clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    @(negedge clk);
    checkEq("ovfCleared", ovf, 0);

    // 5: full FIFO with push and pop in the same cycle
    @(posedge clk);
    #1 evt_ready = 1'b0;
    ctrl_bus = 12'h0FF;
    for (int i = 0; i < 8; i++) expQ.push_back(8'h80 | 8'(i));
    repeat (15) @(posedge clk);
    drive(12'h0FE);
    expQ.push_back(8'h00);
    repeat (3) @(posedge clk);
    #1 evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    @(negedge clk);
    checkEq("fullCount", dut.uFifo.count, 8);
    checkEq("fullOvf", ovf, 0);
    checkEq("fullHead", evt_data, 8'h81);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkEq("fullDrained", expQ.size(), 0);
    drive(12'h000);
    for (int i = 1; i < 8; i++) expQ.push_back(8'(i));
    repeat (14) @(posedge clk);

    // 6: reset while 3 events are queued and K is still pending
    @(posedge clk);
    #1 evt_ready = 1'b0;
    ctrl_bus = 12'h047;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    expQ.delete();
    #1;
    checkEq("midRstValid", evt_valid, 0);
    checkEq("midRstOvf", ovf, 0);
    checkEq("midRstData", evt_data, 0);
    ctrl_bus = 12'h000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    evt_ready = 1'b1;
    waitEvt(20, t0, ok);
    checkEq("noStale", ok, 0);

    // 7: short K pulse cancelled while still waiting behind lower keys
    drive(12'h07F);
    for (int i = 0; i < 6; i++) expQ.push_back(8'h80 | 8'(i));
    drive(12'h03F);
    repeat (15) @(posedge clk);
    drive(12'h000);
    for (int i = 0; i < 6; i++) expQ.push_back(8'(i));
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkEq("finalDrained", expQ.size(), 0);
    checkEq("finalValid", evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
